// File: rtl/prm_scan_pkg.sv
// Shared types and defaults for the PRM edge-scan sequencer.
// Imported by the scan controller and its mask packer.
package prm_scan_pkg;

    localparam int CODE_W = 15;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        FLUSH,
        DRAIN
    } scan_state_e;

    typedef logic [CODE_W-1:0] code_t;

endpackage

// File: rtl/prm_mask_packer.sv
// Packs sampled checker mask bits LSB-first into words and holds each word
// in a valid/ready output register until the downstream stage accepts it.
module prm_mask_packer
    import prm_scan_pkg::*;
#(
    parameter int WORD_W = prm_scan_pkg::WORD_W,
    parameter int CNT_W  = $clog2(WORD_W) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    input  logic              in_bit,
    input  logic              in_last,
    input  logic              flush,
    input  logic [CNT_W-1:0]  inflight,
    input  logic              word_ready,
    output logic [WORD_W-1:0] word_data,
    output logic              word_valid,
    output logic              word_last,
    output logic              room_ok,
    output logic              flush_done
);

    localparam int IDX_W = $clog2(WORD_W);

    logic [WORD_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  acc_cnt_q, acc_cnt_d;
    logic [WORD_W-1:0] word_data_q, word_data_d;
    logic              word_valid_q, word_valid_d;
    logic              word_last_q, word_last_d;
    logic              out_free;
    logic              accept;

    assign accept   = word_valid_q & word_ready;
    assign out_free = ~word_valid_q | word_ready;
    // Bits already counted plus bits still in the checker pipe must fit.
    assign room_ok  = out_free
                    | ((acc_cnt_q + inflight + CNT_W'(1)) < CNT_W'(WORD_W));

    always_comb begin
        acc_d        = acc_q;
        acc_cnt_d    = acc_cnt_q;
        word_data_d  = word_data_q;
        word_valid_d = word_valid_q & ~accept;
        word_last_d  = word_last_q & ~accept;
        flush_done   = 1'b0;
        if (in_valid) begin
            if (acc_cnt_q == CNT_W'(WORD_W - 1)) begin
                word_data_d  = acc_q | (WORD_W'(in_bit) << (WORD_W - 1));
                word_valid_d = 1'b1;
                word_last_d  = in_last;
                acc_d        = '0;
                acc_cnt_d    = '0;
            end else begin
                acc_d[acc_cnt_q[IDX_W-1:0]] = in_bit;
                acc_cnt_d = acc_cnt_q + CNT_W'(1);
            end
        end
        if (flush) begin
            if (acc_cnt_q == '0) begin
                flush_done = 1'b1;
            end else if (out_free) begin
                word_data_d  = acc_q;
                word_valid_d = 1'b1;
                word_last_d  = 1'b1;
                acc_d        = '0;
                acc_cnt_d    = '0;
                flush_done   = 1'b1;
            end
        end
        if (clear) begin
            acc_d        = '0;
            acc_cnt_d    = '0;
            word_data_d  = '0;
            word_valid_d = 1'b0;
            word_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q        <= '0;
            acc_cnt_q    <= '0;
            word_data_q  <= '0;
            word_valid_q <= 1'b0;
            word_last_q  <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            acc_cnt_q    <= acc_cnt_d;
            word_data_q  <= word_data_d;
            word_valid_q <= word_valid_d;
            word_last_q  <= word_last_d;
        end
    end

    assign word_data  = word_data_q;
    assign word_valid = word_valid_q;
    assign word_last  = word_last_q;

endmodule

// File: rtl/prm_edge_scan_ctrl.sv
// Sweeps a range of edge codes through the obstacle-logic checker and
// streams the packed edge masks downstream with a hit count.
module prm_edge_scan_ctrl
    import prm_scan_pkg::*;
#(
    parameter int CODE_W  = prm_scan_pkg::CODE_W,
    parameter int WORD_W  = prm_scan_pkg::WORD_W,
    parameter int CHK_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [CODE_W-1:0] first_code,
    input  logic [CODE_W-1:0] last_code,
    output logic [CODE_W-1:0] chk_code,
    output logic              chk_valid,
    input  logic              chk_mask,
    output logic [WORD_W-1:0] word_data,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              word_last,
    output logic              busy,
    output logic              done,
    output logic [CODE_W:0]   hit_count
);

    localparam int CNT_W = $clog2(WORD_W) + 1;
    localparam int CTR_W = CODE_W + 1;
    localparam logic [CTR_W-1:0] HIT_MAX = {1'b1, {CODE_W{1'b0}}};

    scan_state_e        state_q, state_d;
    logic [CTR_W-1:0]   cur_q, cur_d;
    logic [CTR_W-1:0]   last_q, last_d;
    logic [CTR_W-1:0]   hit_q, hit_d;
    logic [CHK_LAT-1:0] vld_q, vld_d;
    logic [CHK_LAT:0]   vld_sh;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   inflight;
    logic               issue, empty, last_acc;
    logic               in_valid, in_last;
    logic               flush, flush_done, room_ok;

    // A start with first > last leaves cur above last from the first cycle.
    assign empty    = cur_q > last_q;
    assign last_acc = word_valid & word_ready & word_last;
    assign in_valid = vld_q[CHK_LAT-1];

    always_comb begin
        inflight = '0;
        for (int i = 0; i < CHK_LAT; i++) begin
            inflight = inflight + CNT_W'(vld_q[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start) state_d = SCAN;
            SCAN: begin
                if (empty) begin
                    state_d = IDLE;
                end else if (issue && cur_q == last_q) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (last_acc) begin
                    state_d = IDLE;
                end else if (flush_done) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: if (last_acc) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    always_comb begin
        issue   = (state_q == SCAN) & ~empty & room_ok;
        // The final bit lands in FLUSH with nothing else left in the pipe.
        in_last = (state_q == FLUSH) & in_valid & (inflight == CNT_W'(1));
        flush   = (state_q == FLUSH) & (inflight == '0);
        cur_d   = cur_q;
        last_d  = last_q;
        hit_d   = hit_q;
        vld_sh  = {vld_q, issue};
        vld_d   = vld_sh[CHK_LAT-1:0];
        if (state_q == IDLE && start && !abort) begin
            cur_d  = {1'b0, first_code};
            last_d = {1'b0, last_code};
            hit_d  = '0;
        end else if (issue) begin
            cur_d = cur_q + CTR_W'(1);
        end
        if (in_valid && chk_mask && hit_q != HIT_MAX) begin
            hit_d = hit_q + CTR_W'(1);
        end
        done_d = ~abort
               & (((state_q == SCAN) & empty)
               | (((state_q == FLUSH) | (state_q == DRAIN)) & last_acc));
        if (abort) vld_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q  <= '0;
            last_q <= '0;
            hit_q  <= '0;
            vld_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cur_q  <= cur_d;
            last_q <= last_d;
            hit_q  <= hit_d;
            vld_q  <= vld_d;
            done_q <= done_d;
        end
    end

    prm_mask_packer #(
        .WORD_W (WORD_W),
        .CNT_W  (CNT_W)
    ) u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (abort),
        .in_valid   (in_valid),
        .in_bit     (chk_mask),
        .in_last    (in_last),
        .flush      (flush),
        .inflight   (inflight),
        .word_ready (word_ready),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_last  (word_last),
        .room_ok    (room_ok),
        .flush_done (flush_done)
    );

    assign chk_code  = cur_q[CODE_W-1:0];
    assign chk_valid = issue;
    assign busy      = state_q != IDLE;
    assign done      = done_q;
    assign hit_count = hit_q;

endmodule

// File: tb/tb_prm_edge_scan_ctrl.sv
// Randomized bench for prm_edge_scan_ctrl against a range-level packing model.
module tb_prm_edge_scan_ctrl;
    import prm_scan_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort;
    code_t       first_code, last_code, chk_code;
    logic        chk_valid, chk_mask;
    logic [31:0] word_data;
    logic        word_valid, word_ready, word_last;
    logic        busy, done;
    logic [15:0] hit_count;

    always #5 clk = ~clk;

    prm_edge_scan_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .first_code (first_code),
        .last_code  (last_code),
        .chk_code   (chk_code),
        .chk_valid  (chk_valid),
        .chk_mask   (chk_mask),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .word_last  (word_last),
        .busy       (busy),
        .done       (done),
        .hit_count  (hit_count)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } wexp_t;

    int    vecs = 0;
    int    miss = 0;
    int    cyc = 0;
    int    mode = 0;
    int    rdy_mode = 0;
    int    chk_on = 0;
    int    exp_code = 0;
    int    issued = 0;
    int    last_acc_cyc = -100;
    logic  [31:0] last_word_seen = '0;
    wexp_t exp_q[$];
    code_t stub_q;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic mfn(input code_t c, input int m);
        logic [31:0] h;
        h = {17'b0, c} * 32'h9E37_79B1;
        case (m)
            0:       return c[0];
            1:       return 1'b1;
            default: return h[19];
        endcase
    endfunction

    // Checker stand-in with a one-cycle latency.
    always @(posedge clk) stub_q <= chk_code;
    assign chk_mask = mfn(stub_q, mode);

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        word_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       word_ready = 1'b1;
                1:       word_ready = 1'b0;
                default: word_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    logic        prev_hold = 1'b0;
    logic [31:0] prev_d;
    logic        prev_l;

    always @(negedge clk) begin : cmp
        wexp_t w;
        if (rst_n && chk_on != 0) begin
            if (chk_valid) begin
                chk("issue_code", 64'(chk_code), 64'(exp_code));
                exp_code++;
                issued++;
            end
            if (prev_hold) begin
                chk("hold_valid", 64'(word_valid), 64'(1));
                chk("hold_data", 64'(word_data), 64'(prev_d));
                chk("hold_last", 64'(word_last), 64'(prev_l));
            end
            if (word_valid && word_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_word", 64'(word_valid), 64'(0));
                end else begin
                    w = exp_q.pop_front();
                    chk("word_data", 64'(word_data), 64'(w.data));
                    chk("word_last", 64'(word_last), 64'(w.last));
                    last_word_seen = word_data;
                    if (word_last) last_acc_cyc = cyc;
                end
            end
            prev_hold = word_valid & ~word_ready;
            prev_d    = word_data;
            prev_l    = word_last;
        end else begin
            prev_hold = 1'b0;
        end
    end

    task automatic build(input int fc, input int lc, input int m,
                         output int n, output int hits);
        logic [31:0] acc;
        int k;
        logic b;
        exp_q.delete();
        n = 0;
        hits = 0;
        acc = '0;
        k = 0;
        for (int c = fc; c <= lc; c++) begin
            b = mfn(code_t'(c), m);
            acc[k] = b;
            hits += int'(b);
            k++;
            n++;
            if (k == 32 || c == lc) begin
                exp_q.push_back('{data: acc, last: (c == lc)});
                acc = '0;
                k = 0;
            end
        end
    endtask

    task automatic kick(input int fc, input int lc, output int c0);
        @(posedge clk);
        #1;
        first_code = code_t'(fc);
        last_code  = code_t'(lc);
        start = 1'b1;
        c0 = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_scan(input int fc, input int lc, input int m,
                            input int rm, input int hold);
        int n, hits, c0, t, exp_iss;
        mode = m;
        build(fc, lc, m, n, hits);
        exp_code = fc;
        issued = 0;
        last_acc_cyc = -100;
        rdy_mode = (hold > 0) ? 1 : rm;
        repeat (2) @(posedge clk);
        chk_on = 1;
        kick(fc, lc, c0);
        @(negedge clk);
        if (n > 0) begin
            chk("first_issue_v", 64'(chk_valid), 64'(1));
            chk("first_issue_code", 64'(chk_code), 64'(fc));
        end else begin
            chk("empty_no_issue", 64'(chk_valid), 64'(0));
        end
        chk("busy_scan", 64'(busy), 64'(1));
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            exp_iss = (n < 63) ? n : 63;
            chk("stall_issued", 64'(issued), 64'(exp_iss));
            chk("stall_chk_valid", 64'(chk_valid), 64'(0));
            rdy_mode = rm;
        end
        t = 0;
        while (!done && t < 3000 + 8 * n) begin
            @(negedge clk);
            t++;
        end
        if (!done) begin
            chk("done_timeout", 64'(done), 64'(1));
        end else begin
            if (n == 0) chk("done_cyc_empty", 64'(cyc - c0), 64'(2));
            else chk("done_after_last", 64'(cyc - last_acc_cyc), 64'(1));
            chk("hit_count", 64'(hit_count), 64'(hits));
            chk("words_left", 64'(exp_q.size()), 64'(0));
            chk("issued_total", 64'(issued), 64'(n));
            chk("busy_at_done", 64'(busy), 64'(0));
            @(negedge clk);
            chk("done_pulse", 64'(done), 64'(0));
        end
        chk_on = 0;
        rdy_mode = 0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_chk_code"}, 64'(chk_code), 64'(0));
        chk({tag, "_chk_valid"}, 64'(chk_valid), 64'(0));
        chk({tag, "_word_data"}, 64'(word_data), 64'(0));
        chk({tag, "_word_valid"}, 64'(word_valid), 64'(0));
        chk({tag, "_word_last"}, 64'(word_last), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_done"}, 64'(done), 64'(0));
        chk({tag, "_hit_count"}, 64'(hit_count), 64'(0));
    endtask

    task automatic abort_test();
        int c0;
        logic [15:0] h;
        mode = 1;
        rdy_mode = 0;
        exp_q.delete();
        exp_code = 0;
        issued = 0;
        chk_on = 1;
        kick(0, 63, c0);
        repeat (9) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_word_valid", 64'(word_valid), 64'(0));
        chk("abort_chk_valid", 64'(chk_valid), 64'(0));
        chk("abort_issued", 64'(issued), 64'(10));
        chk("abort_hit_range", 64'(hit_count >= 8 && hit_count <= 10), 64'(1));
        h = hit_count;
        for (int i = 0; i < 6; i++) begin
            chk("abort_no_done", 64'(done), 64'(0));
            @(negedge clk);
        end
        chk("abort_hit_hold", 64'(hit_count), 64'(h));
        chk_on = 0;
        @(posedge clk);
        #1;
        first_code = code_t'(0);
        last_code  = code_t'(3);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_over_start", 64'(busy), 64'(0));
    endtask

    task automatic reset_test();
        int c0;
        mode = 1;
        rdy_mode = 0;
        exp_q.delete();
        kick(0, 63, c0);
        repeat (9) @(posedge clk);
        #2;
        chk("pre_reset_busy", 64'(busy), 64'(1));
        rst_n = 1'b0;
        #1;
        check_zero("midrst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("rst_no_done", 64'(done), 64'(0));
        end
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1);
    end

    initial begin
        int fc, lc, len;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        first_code = '0;
        last_code = '0;
        #12;
        check_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_scan(0, 31, 0, 0, 0);
        chk("full_word_lit", 64'(last_word_seen), 64'h0000_0000_AAAA_AAAA);
        chk("full_hit_lit", 64'(hit_count), 64'(16));

        run_scan(100, 139, 1, 0, 0);
        chk("tail_word_lit", 64'(last_word_seen), 64'h0000_0000_0000_00FF);
        chk("tail_hit_lit", 64'(hit_count), 64'(40));

        run_scan(0, 127, 0, 2, 80);
        chk("bp_hit_lit", 64'(hit_count), 64'(64));

        run_scan(5, 4, 1, 0, 0);
        chk("empty_hit_lit", 64'(hit_count), 64'(0));

        run_scan(32767, 32767, 1, 0, 0);
        chk("top_word_lit", 64'(last_word_seen), 64'h1);
        chk("top_hit_lit", 64'(hit_count), 64'(1));

        abort_test();
        reset_test();

        for (int i = 0; i < 12; i++) begin
            fc  = int'($urandom_range(0, 32767));
            len = int'($urandom_range(1, 150));
            lc  = fc + len - 1;
            if (lc > 32767) lc = 32767;
            if (i % 6 == 5 && fc > 0) lc = fc - 1;
            run_scan(fc, lc, 2, 2, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
